// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int INSTR_NOP = 0;
  localparam int PC_STEP   = 4;

  // Counters must hold the value DEPTH itself, hence one extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// In-order circular buffer with synchronous clear; count reports occupancy 0..DEPTH.
module fetch_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 64,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Buffered IF stage: issues imem fetches, queues returned instructions with PC+4,
// and flushes on a decode redirect while discarding responses already in flight.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc_plus4,
  input  logic             decode_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] pc_out,
  output logic             err_spurious
);

  localparam int               CW      = cnt_width(DEPTH);
  localparam logic [WIDTH-1:0] STEP    = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] NOP     = WIDTH'(INSTR_NOP);
  localparam logic [CW:0]      DEPTH_W = (CW+1)'(DEPTH);

  logic [WIDTH-1:0]   pc_f;
  logic [WIDTH-1:0]   resp_pc;
  logic [CW-1:0]      count;
  logic [CW-1:0]      outstanding;
  logic [CW-1:0]      drop_cnt;
  logic [2*WIDTH-1:0] head;
  logic [CW:0]        occupancy;
  logic [WIDTH-1:0]   target_pc;
  logic               pop;
  logic               accept;
  logic               rvalid_ok;
  logic               keep;

  assign pop       = instr_valid && decode_ready;
  assign rvalid_ok = imem_rvalid && (outstanding != '0);
  assign keep      = rvalid_ok && (drop_cnt == '0) && !redirect_valid;
  assign target_pc = redirect_pc & ~WIDTH'(3);

  // Slots already promised to the queue, less the entry leaving this cycle.
  assign occupancy = {1'b0, count} + {1'b0, outstanding} - (CW+1)'(pop);
  assign imem_req  = rst_n && !redirect_valid && (occupancy < DEPTH_W);
  assign accept    = imem_req && imem_gnt;

  assign imem_addr = pc_f;
  assign pc_out    = pc_f;

  // Responses belonging to pre-redirect requests are counted off via drop_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f         <= RESET_PC;
      resp_pc      <= RESET_PC;
      outstanding  <= '0;
      drop_cnt     <= '0;
      err_spurious <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rvalid_ok);
      if (redirect_valid) begin
        pc_f     <= target_pc;
        resp_pc  <= target_pc;
        drop_cnt <= outstanding - CW'(rvalid_ok);
      end else begin
        if (accept) pc_f <= pc_f + STEP;
        if (keep)   resp_pc <= resp_pc + STEP;
        if (rvalid_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
      if (imem_rvalid && (outstanding == '0)) err_spurious <= 1'b1;
    end
  end

  fetch_sync_fifo #(
    .DEPTH(DEPTH),
    .DW   (2*WIDTH),
    .CW   (CW)
  ) u_queue (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(redirect_valid),
    .push (keep),
    .pop  (pop),
    .wdata({imem_rdata, resp_pc + STEP}),
    .rdata(head),
    .count(count)
  );

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head[2*WIDTH-1:WIDTH] : NOP;
  assign pc_plus4    = instr_valid ? head[WIDTH-1:0] : '0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an in-order, fixed-latency memory model.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        decode_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc_out;
  logic        err_spurious;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 1;
  logic spur = 1'b0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } resp_t;
  resp_t pend[$];

  fetch_prefetch_queue #(
    .WIDTH(32),
    .DEPTH(4),
    .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc_plus4      (pc_plus4),
    .decode_ready  (decode_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc_out        (pc_out),
    .err_spurious  (err_spurious)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  // Requests are captured mid-cycle, when the handshake is stable.
  always @(negedge clk) begin
    if (rst_n && imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + lat});
  end

  // Memory is reset alongside the DUT; responses come back in order.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (!rst_n) begin
      pend.delete();
      imem_rvalid = 1'b0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(pend[0].addr);
      void'(pend.pop_front());
    end else if (spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
    end else begin
      imem_rvalid = 1'b0;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic rdy, input logic gnt, input logic redir,
                                input logic [31:0] rpc);
    decode_ready   = rdy;
    imem_gnt       = gnt;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic do_reset(input int latency, input logic rdy, input logic gnt);
    rst_n = 1'b0;
    lat   = latency;
    apply_stimulus(rdy, gnt, 1'b0, 32'h0);
    repeat (2) next_cycle();
    check_output("reset_req", 32'(imem_req), 32'h0);
    check_output("reset_valid", 32'(instr_valid), 32'h0);
    check_output("reset_instr", instr, 32'h0);
    check_output("reset_pc4", pc_plus4, 32'h0);
    check_output("reset_err", 32'(err_spurious), 32'h0);
    check_output("reset_pc", pc_out, 32'h0);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int exp_pc4;
    int pops;

    // Streaming from reset, then a redirect with 1-cycle memory.
    do_reset(1, 1'b1, 1'b1);
    check_output("s_c0_req", 32'(imem_req), 32'h1);
    check_output("s_c0_addr", imem_addr, 32'h0);
    check_output("s_c0_valid", 32'(instr_valid), 32'h0);
    next_cycle();
    check_output("s_c1_addr", imem_addr, 32'h4);
    check_output("s_c1_valid", 32'(instr_valid), 32'h0);
    next_cycle();
    check_output("s_c2_addr", imem_addr, 32'h8);
    check_output("s_c2_valid", 32'(instr_valid), 32'h1);
    check_output("s_c2_pc4", pc_plus4, 32'h4);
    check_output("s_c2_instr", instr, 32'hC0DE_0000);
    next_cycle();
    check_output("s_c3_pc4", pc_plus4, 32'h8);
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h200);
    check_output("rd_t_req", 32'(imem_req), 32'h0);
    next_cycle();
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("rd_t1_valid", 32'(instr_valid), 32'h0);
    check_output("rd_t1_req", 32'(imem_req), 32'h1);
    check_output("rd_t1_addr", imem_addr, 32'h200);
    next_cycle();
    check_output("rd_t2_valid", 32'(instr_valid), 32'h0);
    next_cycle();
    check_output("rd_t3_valid", 32'(instr_valid), 32'h1);
    check_output("rd_t3_pc4", pc_plus4, 32'h204);
    check_output("rd_t3_instr", instr, 32'hC0DE_0200);

    // Decode stalled for 10 cycles: queue fills to DEPTH, then drains in order.
    do_reset(1, 1'b0, 1'b1);
    repeat (3) next_cycle();
    check_output("st_c3_addr", imem_addr, 32'hC);
    check_output("st_c3_req", 32'(imem_req), 32'h1);
    next_cycle();
    check_output("st_c4_req", 32'(imem_req), 32'h0);
    next_cycle();
    check_output("st_c5_req", 32'(imem_req), 32'h0);
    check_output("st_c5_pc4", pc_plus4, 32'h4);
    check_output("st_c5_pc", pc_out, 32'h10);
    repeat (4) next_cycle();
    check_output("st_c9_req", 32'(imem_req), 32'h0);
    next_cycle();
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("st_c10_req", 32'(imem_req), 32'h1);
    check_output("st_c10_addr", imem_addr, 32'h10);
    check_output("st_c10_pc4", pc_plus4, 32'h4);
    next_cycle();
    check_output("st_c11_pc4", pc_plus4, 32'h8);
    next_cycle();
    check_output("st_c12_pc4", pc_plus4, 32'hC);
    next_cycle();
    check_output("st_c13_pc4", pc_plus4, 32'h10);
    check_output("st_c13_instr", instr, 32'hC0DE_000C);
    next_cycle();
    check_output("st_c14_pc4", pc_plus4, 32'h14);

    // Latency-3 memory: redirect with two requests in flight, target misaligned.
    do_reset(3, 1'b1, 1'b1);
    next_cycle();
    check_output("l3_c1_addr", imem_addr, 32'h4);
    next_cycle();
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h103);
    check_output("l3_c2_req", 32'(imem_req), 32'h0);
    next_cycle();
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    check_output("l3_c3_req", 32'(imem_req), 32'h1);
    check_output("l3_c3_addr", imem_addr, 32'h100);
    check_output("l3_c3_valid", 32'(instr_valid), 32'h0);
    next_cycle();
    check_output("l3_c4_addr", imem_addr, 32'h104);
    check_output("l3_c4_valid", 32'(instr_valid), 32'h0);
    next_cycle();
    check_output("l3_c5_valid", 32'(instr_valid), 32'h0);
    next_cycle();
    check_output("l3_c6_valid", 32'(instr_valid), 32'h0);
    next_cycle();
    check_output("l3_c7_valid", 32'(instr_valid), 32'h1);
    check_output("l3_c7_pc4", pc_plus4, 32'h104);
    check_output("l3_c7_instr", instr, 32'hC0DE_0100);

    // Grant toggling with overlapping push and pop: no loss, no duplicates.
    do_reset(1, 1'b0, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    next_cycle();
    exp_pc4 = 4;
    pops    = 0;
    for (int c = 3; c <= 18; c++) begin
      apply_stimulus(1'b1, (c % 2) == 0, 1'b0, 32'h0);
      if (instr_valid) begin
        check_output("tg_pc4", pc_plus4, 32'(exp_pc4));
        check_output("tg_instr", instr, mem_data(32'(exp_pc4 - 4)));
        exp_pc4 += 4;
        pops++;
      end
      next_cycle();
    end
    check_output("tg_pops", 32'(pops), 32'd9);
    check_output("tg_last", 32'(exp_pc4), 32'h28);

    // Spurious response with nothing outstanding.
    do_reset(1, 1'b1, 1'b0);
    spur = 1'b1;
    next_cycle();
    spur = 1'b0;
    check_output("sp_c1_err", 32'(err_spurious), 32'h0);
    next_cycle();
    check_output("sp_c2_err", 32'(err_spurious), 32'h1);
    check_output("sp_c2_valid", 32'(instr_valid), 32'h0);
    check_output("sp_c2_instr", instr, 32'h0);
    check_output("sp_c2_pc", pc_out, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) next_cycle();
    check_output("sp_c4_err", 32'(err_spurious), 32'h1);
    check_output("sp_c4_valid", 32'(instr_valid), 32'h1);
    check_output("sp_c4_pc4", pc_plus4, 32'h4);

    // Reset asserted with three queued entries clears outputs immediately.
    do_reset(1, 1'b0, 1'b1);
    repeat (4) next_cycle();
    check_output("mr_pre_valid", 32'(instr_valid), 32'h1);
    check_output("mr_pre_pc4", pc_plus4, 32'h4);
    rst_n = 1'b0;
    #1;
    check_output("mr_valid", 32'(instr_valid), 32'h0);
    check_output("mr_instr", instr, 32'h0);
    check_output("mr_pc4", pc_plus4, 32'h0);
    check_output("mr_req", 32'(imem_req), 32'h0);
    check_output("mr_pc", pc_out, 32'h0);
    repeat (2) next_cycle();
    rst_n = 1'b1;
    #1;
    check_output("mr_c0_req", 32'(imem_req), 32'h1);
    check_output("mr_c0_addr", imem_addr, 32'h0);
    next_cycle();
    check_output("mr_c1_addr", imem_addr, 32'h4);
    check_output("mr_c1_err", 32'(err_spurious), 32'h0);
    next_cycle();
    check_output("mr_c2_valid", 32'(instr_valid), 32'h1);
    check_output("mr_c2_pc4", pc_plus4, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
